// File: rtl/riscv_rv64i_insn_gen_if.sv
// rtl/riscv_rv64i_insn_gen_if.sv - instruction-word stream interface
// Purpose: carries generated instruction words from producer to consumer.
// Signals:
//   out_valid  producer -> consumer  word on out_insn is valid
//   out_ready  consumer -> producer  consumer accepts the word this cycle
//   out_insn   producer -> consumer  32-bit instruction word
interface riscv_rv64i_insn_gen_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;

  modport master (output out_valid, output out_insn, input out_ready);
  modport slave  (input out_valid, input out_insn, output out_ready);
endinterface

// File: rtl/riscv_rv64i_insn_gen.sv
// rtl/riscv_rv64i_insn_gen.sv - burst generator of legal RV64I (non-SYSTEM) instruction words
// Purpose: on start, emits len legal RV64I words over a valid/ready stream.
//   Each word comes from a 32-bit Galois LFSR whose fields are then legalized.
// Ports:
//   clock    in   rising-edge clock
//   resetn   in   asynchronous active-low reset
//   start    in   begin burst (sampled only in IDLE)
//   len      in   [15:0] burst length, sampled with start
//   sweep    in   1: class from round-robin counter, 0: class from LFSR
//   out      master modport: out_valid / out_ready / out_insn
//   busy     out  state != IDLE
//   done     out  one-cycle pulse at end of burst
//   emitted  out  [15:0] words accepted in current or last burst
module riscv_rv64i_insn_gen #(
  parameter logic [31:0] SEED = 32'h00000001
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [15:0]                   len,
  input  logic                          sweep,
  riscv_rv64i_insn_gen_if.master        out,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   emitted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h00000001 : SEED;
  localparam logic [31:0] POLY     = 32'h80200003;

  logic [1:0]  state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [3:0]  cls_q, cls_d;
  logic [15:0] remaining_q, remaining_d;
  logic        sweep_q, sweep_d;
  logic [15:0] emitted_q, emitted_d;
  logic        valid_q, valid_d;
  logic [31:0] insn_q, insn_d;

  logic        load;
  logic        use_sweep;
  logic [3:0]  cls_cur;
  logic [3:0]  rand_cls;
  logic [3:0]  cls_sel;

  // Raw LFSR bits for everything above the opcode, then per-class fixups so
  // that funct3/funct7 always land on a defined RV64I encoding.
  function automatic logic [31:0] build(input logic [31:0] l, input logic [3:0] c);
    logic [31:0] w;
    logic [2:0]  f;
    logic [2:0]  fw;
    logic        s;
    w = {l[31:7], 7'b0000000};
    f = l[14:12];
    s = l[30];
    case (f[1:0])
      2'b00:   fw = 3'b000;
      2'b01:   fw = 3'b001;
      2'b10:   fw = 3'b101;
      default: fw = 3'b000;
    endcase
    case (c)
      4'd0: w[6:0] = 7'b0110111;
      4'd1: w[6:0] = 7'b0010111;
      4'd2: w[6:0] = 7'b1101111;
      4'd3: begin
        w[6:0]   = 7'b1100111;
        w[14:12] = 3'b000;
      end
      4'd4: begin
        w[6:0] = 7'b1100011;
        if (f == 3'b010)      w[14:12] = 3'b000;
        else if (f == 3'b011) w[14:12] = 3'b001;
      end
      4'd5: begin
        w[6:0] = 7'b0000011;
        if (f == 3'b111) w[14:12] = 3'b011;
      end
      4'd6: begin
        w[6:0]   = 7'b0100011;
        w[14:12] = {1'b0, f[1:0]};
      end
      4'd7: begin
        // RV64 shifts use a 6-bit shamt, so only insn[31:26] is constrained.
        w[6:0] = 7'b0010011;
        if (f == 3'b001)      w[31:26] = 6'b000000;
        else if (f == 3'b101) w[31:26] = {1'b0, s, 4'b0000};
      end
      4'd8: begin
        w[6:0] = 7'b0110011;
        if (f == 3'b000 || f == 3'b101) w[31:25] = {1'b0, s, 5'b00000};
        else                             w[31:25] = 7'b0000000;
      end
      4'd9: begin
        // ADDIW (mapped 000) keeps its full random immediate.
        w[6:0]   = 7'b0011011;
        w[14:12] = fw;
        if (fw == 3'b001)      w[31:25] = 7'b0000000;
        else if (fw == 3'b101) w[31:25] = {1'b0, s, 5'b00000};
      end
      4'd10: begin
        w[6:0]   = 7'b0111011;
        w[14:12] = fw;
        if (fw == 3'b001) w[31:25] = 7'b0000000;
        else              w[31:25] = {1'b0, s, 5'b00000};
      end
      default: w[6:0] = 7'b0110111;
    endcase
    return w;
  endfunction

  assign rand_cls = (lfsr_q[3:0] >= 4'd11) ? (lfsr_q[3:0] - 4'd11) : lfsr_q[3:0];
  assign cls_sel  = use_sweep ? cls_cur : rand_cls;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cls_d       = cls_q;
    remaining_d = remaining_q;
    sweep_d     = sweep_q;
    emitted_d   = emitted_q;
    valid_d     = valid_q;
    insn_d      = insn_q;
    load        = 1'b0;
    use_sweep   = sweep_q;
    cls_cur     = cls_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          emitted_d = 16'd0;
          if (len != 16'd0) begin
            // The first load must already use the mode and class being latched.
            remaining_d = len;
            sweep_d     = sweep;
            use_sweep   = sweep;
            cls_d       = 4'd0;
            cls_cur     = 4'd0;
            load        = 1'b1;
            state_d     = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (out.out_ready) begin
          emitted_d   = emitted_q + 16'd1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            valid_d = 1'b0;
            state_d = S_DONE;
          end else begin
            load = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      insn_d  = build(lfsr_q, cls_sel);
      lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 32'h0);
      valid_d = 1'b1;
      if (use_sweep) cls_d = (cls_cur == 4'd10) ? 4'd0 : cls_cur + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_EFF;
      cls_q       <= 4'd0;
      remaining_q <= 16'd0;
      sweep_q     <= 1'b0;
      emitted_q   <= 16'd0;
      valid_q     <= 1'b0;
      insn_q      <= 32'h0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cls_q       <= cls_d;
      remaining_q <= remaining_d;
      sweep_q     <= sweep_d;
      emitted_q   <= emitted_d;
      valid_q     <= valid_d;
      insn_q      <= insn_d;
    end
  end

  assign out.out_valid = valid_q;
  assign out.out_insn  = insn_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign emitted       = emitted_q;

endmodule

// File: tb/tb_riscv_rv64i_insn_gen.sv
// tb/tb_riscv_rv64i_insn_gen.sv - self-checking bench for riscv_rv64i_insn_gen
module tb_riscv_rv64i_insn_gen;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [15:0] len;
  logic        sweep;
  logic        busy;
  logic        done;
  logic [15:0] emitted;

  riscv_rv64i_insn_gen_if bus ();

  riscv_rv64i_insn_gen #(.SEED(32'h00000001)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .start   (start),
    .len     (len),
    .sweep   (sweep),
    .out     (bus),
    .busy    (busy),
    .done    (done),
    .emitted (emitted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [31:0] got[$];
  int done_seen;

  typedef struct {
    int          cls;
    logic [31:0] exp_insn;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Independent RV64I legality oracle: returns class index, or -1 if illegal.
  function automatic int legal_class(input logic [31:0] w);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] f6;
    f3 = w[14:12];
    f7 = w[31:25];
    f6 = w[31:26];
    case (w[6:0])
      7'b0110111: return 0;
      7'b0010111: return 1;
      7'b1101111: return 2;
      7'b1100111: return (f3 == 3'd0) ? 3 : -1;
      7'b1100011: return (f3 == 3'd2 || f3 == 3'd3) ? -1 : 4;
      7'b0000011: return (f3 == 3'd7) ? -1 : 5;
      7'b0100011: return (f3[2] == 1'b0) ? 6 : -1;
      7'b0010011: begin
        if (f3 == 3'd1) return (f6 == 6'd0) ? 7 : -1;
        if (f3 == 3'd5) return (f6 == 6'd0 || f6 == 6'b010000) ? 7 : -1;
        return 7;
      end
      7'b0110011: return (f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))) ? 8 : -1;
      7'b0011011: begin
        if (f3 == 3'd0) return 9;
        if (f3 == 3'd1) return (f7 == 7'd0) ? 9 : -1;
        if (f3 == 3'd5) return (f7 == 7'd0 || f7 == 7'b0100000) ? 9 : -1;
        return -1;
      end
      7'b0111011: begin
        if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) return -1;
        return (f7 == 7'd0 || (f7 == 7'b0100000 && f3 != 3'd1)) ? 10 : -1;
      end
      default: return -1;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    start  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic start_burst(input logic [15:0] n, input logic sw);
    @(negedge clock);
    start = 1'b1;
    len   = n;
    sweep = sw;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Collects n accepted words into got[]; then checks the done pulse and emitted.
  task automatic collect(input int n, input bit rnd, input string tag);
    int cyc;
    got.delete();
    done_seen = 0;
    cyc = 0;
    while (got.size() < n && cyc < 60000) begin
      @(negedge clock);
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) done_seen++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_insn);
      cyc++;
    end
    check({tag, "_count"}, got.size(), n);
    @(negedge clock);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
    check({tag, "_valid_low"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_emitted"}, {16'd0, emitted}, n);
    check({tag, "_early_done"}, done_seen, 0);
    @(negedge clock);
    check({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int bad;
    int seen_mask;
    int c;

    vecs[0]  = '{0,  32'h00000037};
    vecs[1]  = '{1,  32'h80200017};
    vecs[2]  = '{2,  32'hC030006F};
    vecs[3]  = '{3,  32'h60180067};
    vecs[4]  = '{4,  32'hB02C0063};
    vecs[5]  = '{5,  32'hD8360003};
    vecs[6]  = '{6,  32'h6C1B0023};
    vecs[7]  = '{7,  32'hB62D8013};
    vecs[8]  = '{8,  32'h0136C033};
    vecs[9]  = '{9,  32'h419B501B};
    vecs[10] = '{10, 32'h00ED803B};

    resetn = 1'b0;
    start  = 1'b0;
    len    = 16'd0;
    sweep  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_valid",   {31'd0, bus.out_valid}, 32'd0);
    check("rst_insn",    bus.out_insn, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_done",    {31'd0, done}, 32'd0);
    check("rst_emitted", {16'd0, emitted}, 32'd0);
    resetn = 1'b1;

    // Two-word sweep burst from the reset seed.
    start_burst(16'd2, 1'b1);
    collect(2, 1'b0, "t1");
    if (got.size() == 2) begin
      check("t1_word0", got[0], 32'h00000037);
      check("t1_word1", got[1], 32'h80200017);
    end

    // Table: one full sweep of classes from the reset seed.
    do_reset();
    start_burst(16'd11, 1'b1);
    collect(11, 1'b0, "tab");
    for (int i = 0; i < 11; i++) begin
      if (i < got.size()) begin
        check($sformatf("tab_insn%0d", i), got[i], vecs[i].exp_insn);
        check($sformatf("tab_cls%0d", i), legal_class(got[i]), vecs[i].cls);
      end
    end

    // Backpressure holds the word and does not advance the LFSR.
    do_reset();
    start_burst(16'd3, 1'b1);
    @(negedge clock);
    bus.out_ready = 1'b1;
    check("bp_w0", bus.out_insn, 32'h00000037);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus.out_ready = 1'b0;
      check($sformatf("bp_hold_insn%0d", i), bus.out_insn, 32'h80200017);
      check($sformatf("bp_hold_valid%0d", i), {31'd0, bus.out_valid}, 32'd1);
    end
    @(negedge clock);
    bus.out_ready = 1'b1;
    check("bp_resume_w1", bus.out_insn, 32'h80200017);
    @(negedge clock);
    check("bp_w2", bus.out_insn, 32'hC030006F);
    @(negedge clock);
    check("bp_done", {31'd0, done}, 32'd1);
    check("bp_emitted", {16'd0, emitted}, 32'd3);
    @(negedge clock);

    // Zero-length burst.
    bus.out_ready = 1'b1;
    start_burst(16'd0, 1'b1);
    @(negedge clock);
    check("z_done",    {31'd0, done}, 32'd1);
    check("z_busy",    {31'd0, busy}, 32'd1);
    check("z_valid",   {31'd0, bus.out_valid}, 32'd0);
    check("z_emitted", {16'd0, emitted}, 32'd0);
    @(negedge clock);
    check("z_done_clr", {31'd0, done}, 32'd0);
    check("z_busy_clr", {31'd0, busy}, 32'd0);
    check("z_valid2",   {31'd0, bus.out_valid}, 32'd0);

    // Two sweeps in class order, all legal.
    start_burst(16'd22, 1'b1);
    collect(22, 1'b0, "sw");
    bad = 0;
    for (int i = 0; i < got.size(); i++)
      if (legal_class(got[i]) != (i % 11)) bad++;
    check("sw_class_order", bad, 0);

    // Long random burst with random backpressure.
    start_burst(16'd10000, 1'b0);
    collect(10000, 1'b1, "rnd");
    bad = 0;
    seen_mask = 0;
    for (int i = 0; i < got.size(); i++) begin
      c = legal_class(got[i]);
      if (c < 0) bad++;
      else seen_mask = seen_mask | (1 << c);
    end
    check("rnd_illegal", bad, 0);
    check("rnd_classes", seen_mask, 32'h7FF);

    // Reset in the middle of a burst.
    start_burst(16'd5, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("mr_valid",   {31'd0, bus.out_valid}, 32'd0);
    check("mr_insn",    bus.out_insn, 32'd0);
    check("mr_busy",    {31'd0, busy}, 32'd0);
    check("mr_done",    {31'd0, done}, 32'd0);
    check("mr_emitted", {16'd0, emitted}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    resetn = 1'b1;
    @(negedge clock);
    if (done) done_seen++;
    check("mr_no_done", done_seen, 0);
    start_burst(16'd1, 1'b1);
    collect(1, 1'b0, "mr2");
    if (got.size() == 1) check("mr2_word0", got[0], 32'h00000037);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
